dcache_responder: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers the CPU core's data-memory port (`dcache_addr`/`dcache_we`/`dcache_re`/`dcache_din` in, `dcache_dout`/`stall` out) and refills from a word-wide backing memory over a valid/ready request channel with an in-order response channel. It sits between the core and the memory arbiter, replacing the fixed-latency data RAM. It drives the core's global `stall` on misses and write-throughs.

---
 rtl/dcache_responder.sv | 216 +++++++++++++++++++++
 tb/tb_dcache_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped, write-through, no-write-allocate data cache
// between the core's data port and a valid/ready backing memory.
// Optional build macro DCACHE_UNCACHED_EN: addresses with bit 31 set bypass
// the cache (single-word read, no allocation; writes behave as write misses).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | lookup of the registered request; hits answer immediately
// FILL   | line refill (or single uncached read) from backing memory
// WT     | write-through request held until the memory accepts it
// RESP   | miss/write completion cycle, core released for one beat
module dcache_responder #(
    parameter int LOGSETS    = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_we,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata
);
    localparam int WOFF   = $clog2(LINE_WORDS);
    localparam int IDX_LO = WOFF + 2;
    localparam int TAG_LO = IDX_LO + LOGSETS;
    localparam int TAGW   = 32 - TAG_LO;
    localparam int SETS   = 1 << LOGSETS;
    localparam int CW     = WOFF + 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WT, S_RESP} state_t;

    state_t state, state_next;

    logic [31:2]         req_addr;
    logic                req_re;
    logic [3:0]          req_we;
    logic [31:0]         req_din;

    logic [SETS-1:0]     line_valid;
    logic [TAGW-1:0]     tag_arr  [SETS];
    logic [31:0]         data_arr [SETS*LINE_WORDS];

    logic [CW-1:0]       req_cnt;
    logic [CW-1:0]       resp_cnt;
    logic [CW-1:0]       req_cnt_inc;
    logic [CW-1:0]       fill_words;
    logic                fill_unc;
    logic [31:0]         cap_word;

    logic [LOGSETS-1:0]  req_idx;
    logic [TAGW-1:0]     req_tag;
    logic [WOFF-1:0]     req_word;
    logic                is_write;
    logic                is_read;
    logic                uncached;
    logic                tag_hit;
    logic                resp_last;
    logic [31:0]         hit_word;
    logic                unused_addr_bits;

    // Byte offset is irrelevant: the cache always works on whole words.
    assign unused_addr_bits = ^dcache_addr[1:0];

    assign req_idx  = req_addr[TAG_LO-1:IDX_LO];
    assign req_tag  = req_addr[31:TAG_LO];
    assign req_word = req_addr[IDX_LO-1:2];
    assign is_write = |req_we;
    assign is_read  = req_re & ~is_write;

`ifdef DCACHE_UNCACHED_EN
    assign uncached = req_addr[31];
`else
    assign uncached = 1'b0;
`endif

    assign hit_word    = data_arr[{req_idx, req_word}];
    assign tag_hit     = line_valid[req_idx] && (tag_arr[req_idx] == req_tag) && !uncached;
    assign fill_words  = fill_unc ? CW'(1) : CW'(LINE_WORDS);
    assign req_cnt_inc = req_cnt + CW'(1);
    assign resp_last   = mem_resp_valid && ((resp_cnt + CW'(1)) == fill_words);

    // Request register: captures the core's access whenever it is not frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr <= '0;
            req_re   <= 1'b0;
            req_we   <= '0;
            req_din  <= '0;
        end else if (!stall) begin
            req_addr <= dcache_addr[31:2];
            req_re   <= dcache_re;
            req_we   <= dcache_we;
            req_din  <= dcache_din;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a request with both re and we set is a write.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (is_write)
                    state_next = S_WT;
                else if (req_re && !tag_hit)
                    state_next = S_FILL;
            end
            S_FILL: if (resp_last)     state_next = S_RESP;
            S_WT:   if (mem_req_ready) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Core-facing outputs: depend only on state and the registered lookup.
    always_comb begin
        stall       = 1'b0;
        dcache_dout = '0;
        case (state)
            S_IDLE: begin
                stall = (req_re | is_write) & ~(is_read & tag_hit);
                if (is_read && tag_hit)
                    dcache_dout = hit_word;
            end
            S_FILL, S_WT: stall = 1'b1;
            S_RESP: dcache_dout = cap_word;
            default: ;
        endcase
    end

    // Memory request channel, refill counters, captured word and valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= '0;
            mem_req_wdata <= '0;
            req_cnt       <= '0;
            resp_cnt      <= '0;
            fill_unc      <= 1'b0;
            cap_word      <= '0;
            line_valid    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (state_next == S_FILL) begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= uncached ? {req_addr, 2'b00}
                                                  : {req_addr[31:IDX_LO], {WOFF{1'b0}}, 2'b00};
                        mem_req_we    <= '0;
                        req_cnt       <= '0;
                        resp_cnt      <= '0;
                        fill_unc      <= uncached;
                    end else if (state_next == S_WT) begin
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {req_addr, 2'b00};
                        mem_req_we    <= req_we;
                        mem_req_wdata <= req_din;
                        cap_word      <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_req_valid && mem_req_ready) begin
                        req_cnt <= req_cnt_inc;
                        if (req_cnt_inc == fill_words)
                            mem_req_valid <= 1'b0;
                        else
                            mem_req_addr <= {req_addr[31:IDX_LO], req_cnt_inc[WOFF-1:0], 2'b00};
                    end
                    if (mem_resp_valid) begin
                        resp_cnt <= resp_cnt + CW'(1);
                        if (fill_unc || (resp_cnt[WOFF-1:0] == req_word))
                            cap_word <= mem_resp_rdata;
                    end
                    if (resp_last && !fill_unc)
                        line_valid[req_idx] <= 1'b1;
                end
                S_WT: begin
                    if (mem_req_ready)
                        mem_req_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: store-hit byte merge and refill writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_IDLE && is_write && tag_hit) begin
                for (int b = 0; b < 4; b++)
                    if (req_we[b])
                        data_arr[{req_idx, req_word}][8*b +: 8] <= req_din[8*b +: 8];
            end
            if (state == S_FILL && mem_resp_valid && !fill_unc)
                data_arr[{req_idx, resp_cnt[WOFF-1:0]}] <= mem_resp_rdata;
            if (state == S_FILL && resp_last && !fill_unc)
                tag_arr[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Testbench for dcache_responder: table of CPU accesses with hand-computed
// data, stall counts and memory traffic, plus directed multi-cycle sequences
// (ready back-pressure, reset mid-refill, uncached reads).
module tb_dcache_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_we;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    always #5 clk = ~clk;

    dcache_responder dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    // Backing memory: sparse map of the addresses the test touches.
    logic [31:0] mem [256];
    logic        mem_loaded = 1'b0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_resp = 0;
    logic [31:0] rd_log [64];
    logic [31:0] wr_log_addr [64];
    logic [3:0]  wr_log_we [64];
    logic [31:0] wr_log_data [64];

    function automatic logic [7:0] midx(input logic [31:0] a);
        return {a[31], a[14:12], a[5:2]};
    endfunction

    function automatic logic [31:0] init_word(input int i);
        logic [7:0]  x;
        logic [31:0] a;
        x = i[7:0];
        a = {x[7], 16'h0, x[6:4], 6'h0, x[3:0], 2'b00};
        if (a[31:4] == 28'h0000100)
            return 32'hA0 + 32'(a[3:2]);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] m;
        m = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end
        if (reset) begin
            mem_resp_valid <= 1'b0;
        end else begin
            mem_resp_valid <= 1'b0;
            if (mem_resp_valid) n_resp <= n_resp + 1;
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we == 4'b0) begin
                    mem_resp_valid     <= 1'b1;
                    mem_resp_rdata     <= mem[midx(mem_req_addr)];
                    rd_log[n_rd[5:0]]  <= mem_req_addr;
                    n_rd               <= n_rd + 1;
                end else begin
                    mem[midx(mem_req_addr)] <= merge(mem[midx(mem_req_addr)], mem_req_wdata, mem_req_we);
                    wr_log_addr[n_wr[5:0]]  <= mem_req_addr;
                    wr_log_we[n_wr[5:0]]    <= mem_req_we;
                    wr_log_data[n_wr[5:0]]  <= mem_req_wdata;
                    n_wr                    <= n_wr + 1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        dcache_addr = '0;
        dcache_re   = 1'b0;
        dcache_we   = '0;
        dcache_din  = '0;
    endtask

    // Issue one access from a non-stalled cycle; returns data and stall cycles.
    task automatic do_op(input logic [31:0] a, input logic re, input logic [3:0] we,
                         input logic [31:0] din, output logic [31:0] dout, output int stalls);
        dcache_addr = a;
        dcache_re   = re;
        dcache_we   = we;
        dcache_din  = din;
        @(posedge clk); #1;
        idle_inputs();
        stalls = 0;
        while (stall && stalls < 200) begin
            stalls++;
            @(posedge clk); #1;
        end
        dout = dcache_dout;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic [3:0]  we;
        logic [31:0] din;
        logic [31:0] exp_dout;
        int          exp_stall;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs[16];

    task automatic check_reset_outputs(input string tag);
        check({tag, " stall"},         32'(stall),         32'h0);
        check({tag, " dout"},          dcache_dout,        32'h0);
        check({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'h0);
        check({tag, " mem_req_addr"},  mem_req_addr,       32'h0);
        check({tag, " mem_req_we"},    32'(mem_req_we),    32'h0);
        check({tag, " mem_req_wdata"}, mem_req_wdata,      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dout;
        int          stalls;
        int          rd0, wr0, rs0, cyc;

        vecs[0]  = '{32'h0000_1004, 1'b1, 4'h0, 32'h0,         32'h0000_00A1, 6, 4, 0};
        vecs[1]  = '{32'h0000_1004, 1'b1, 4'h0, 32'h0,         32'h0000_00A1, 0, 0, 0};
        vecs[2]  = '{32'h0000_100C, 1'b1, 4'h0, 32'h0,         32'h0000_00A3, 0, 0, 0};
        vecs[3]  = '{32'h0000_1000, 1'b1, 4'h0, 32'h0,         32'h0000_00A0, 0, 0, 0};
        vecs[4]  = '{32'h0000_1004, 1'b0, 4'h2, 32'h0000_BB00, 32'h0,         2, 0, 1};
        vecs[5]  = '{32'h0000_1004, 1'b1, 4'h0, 32'h0,         32'h0000_BBA1, 0, 0, 0};
        vecs[6]  = '{32'h0000_2000, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0,         2, 0, 1};
        vecs[7]  = '{32'h0000_1000, 1'b1, 4'h0, 32'h0,         32'h0000_00A0, 0, 0, 0};
        vecs[8]  = '{32'h0000_2000, 1'b1, 4'h0, 32'h0,         32'hDEAD_BEEF, 6, 4, 0};
        vecs[9]  = '{32'h0000_1004, 1'b1, 4'h0, 32'h0,         32'h0000_BBA1, 6, 4, 0};
        vecs[10] = '{32'h0000_1008, 1'b0, 4'hF, 32'h1234_5678, 32'h0,         2, 0, 1};
        vecs[11] = '{32'h0000_1008, 1'b1, 4'h0, 32'h0,         32'h1234_5678, 0, 0, 0};
        vecs[12] = '{32'h0000_1010, 1'b1, 4'h0, 32'h0,         32'h5A5A_1010, 6, 4, 0};
        vecs[13] = '{32'h0000_1010, 1'b1, 4'h1, 32'h0000_00EE, 32'h0,         2, 0, 1};
        vecs[14] = '{32'h0000_1010, 1'b1, 4'h0, 32'h0,         32'h5A5A_10EE, 0, 0, 0};
        vecs[15] = '{32'h0000_1010, 1'b0, 4'h0, 32'h0,         32'h0,         0, 0, 0};

        reset         = 1'b1;
        mem_req_ready = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 16; i++) begin
            rd0 = n_rd;
            wr0 = n_wr;
            do_op(vecs[i].addr, vecs[i].re, vecs[i].we, vecs[i].din, dout, stalls);
            check($sformatf("v%0d dout", i),   dout,                 vecs[i].exp_dout);
            check($sformatf("v%0d stalls", i), 32'(stalls),          32'(vecs[i].exp_stall));
            check($sformatf("v%0d reads", i),  32'(n_rd - rd0),      32'(vecs[i].exp_rd));
            check($sformatf("v%0d writes", i), 32'(n_wr - wr0),      32'(vecs[i].exp_wr));
        end

        check("fill order w0", rd_log[0], 32'h0000_1000);
        check("fill order w1", rd_log[1], 32'h0000_1004);
        check("fill order w2", rd_log[2], 32'h0000_1008);
        check("fill order w3", rd_log[3], 32'h0000_100C);
        check("wt0 addr", wr_log_addr[0],     32'h0000_1004);
        check("wt0 we",   32'(wr_log_we[0]),  32'h2);
        check("wt0 data", wr_log_data[0],     32'h0000_BB00);
        check("wt1 addr", wr_log_addr[1],     32'h0000_2000);
        check("wt1 we",   32'(wr_log_we[1]),  32'hF);

        // Back-pressure: ready low for 5 cycles at the start of a refill.
        rd0 = n_rd;
        mem_req_ready = 1'b0;
        dcache_addr = 32'h0000_3004;
        dcache_re   = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        check("bp lookup stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d valid", k), 32'(mem_req_valid), 32'h1);
            check($sformatf("bp%0d addr", k),  mem_req_addr,       32'h0000_3000);
            check($sformatf("bp%0d stall", k), 32'(stall),         32'h1);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        cyc = 0;
        while (stall && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("bp stall released", 32'(stall), 32'h0);
        check("bp dout",   dcache_dout,     32'h5A5A_3004);
        check("bp reads",  32'(n_rd - rd0), 32'h4);
        check("bp order3", rd_log[(rd0 + 3) % 64], 32'h0000_300C);
        do_op(32'h0000_300C, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("bp reread dout",   dout,        32'h5A5A_300C);
        check("bp reread stalls", 32'(stalls), 32'h0);

        // Reset in the middle of a refill, after two responses.
        rs0 = n_resp;
        dcache_addr = 32'h0000_4008;
        dcache_re   = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        cyc = 0;
        while ((n_resp - rs0) < 2 && cyc < 50) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("mid-fill responses", 32'(n_resp - rs0), 32'h2);
        check("mid-fill stall",     32'(stall),        32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        rd0 = n_rd;
        do_op(32'h0000_4008, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("post-reset dout",   dout,            32'h5A5A_4008);
        check("post-reset stalls", 32'(stalls),     32'h6);
        check("post-reset reads",  32'(n_rd - rd0), 32'h4);
        do_op(32'h0000_1010, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("valid cleared dout",   dout,        32'h5A5A_10EE);
        check("valid cleared stalls", 32'(stalls), 32'h6);

        // Reads of 0x8000_0000: bypass when uncached, ordinary line otherwise.
        rd0 = n_rd;
        do_op(32'h8000_0000, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("hi read1 dout", dout, 32'hDA5A_0000);
`ifdef DCACHE_UNCACHED_EN
        check("unc read1 stalls", 32'(stalls),     32'h3);
        check("unc read1 reads",  32'(n_rd - rd0), 32'h1);
        check("unc read1 addr",   rd_log[rd0 % 64], 32'h8000_0000);
        rd0 = n_rd;
        do_op(32'h8000_0000, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("unc read2 dout",   dout,            32'hDA5A_0000);
        check("unc read2 stalls", 32'(stalls),     32'h3);
        check("unc read2 reads",  32'(n_rd - rd0), 32'h1);
        do_op(32'h0000_4008, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("unc no alloc dout",   dout,        32'h5A5A_4008);
        check("unc no alloc stalls", 32'(stalls), 32'h0);
`else
        check("hi read1 stalls", 32'(stalls),     32'h6);
        check("hi read1 reads",  32'(n_rd - rd0), 32'h4);
        rd0 = n_rd;
        do_op(32'h8000_0000, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("hi read2 dout",   dout,            32'hDA5A_0000);
        check("hi read2 stalls", 32'(stalls),     32'h0);
        check("hi read2 reads",  32'(n_rd - rd0), 32'h0);
        do_op(32'h0000_4008, 1'b1, 4'h0, 32'h0, dout, stalls);
        check("hi evict dout",   dout,        32'h5A5A_4008);
        check("hi evict stalls", 32'(stalls), 32'h6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
